// File: rtl/store_queue_pkg.sv
// Shared types and helpers for the store queue: entry layout and wrap-safe sequence-number ordering.
package sq_pkg;
  localparam int SQN_W     = 7;
  localparam int DEPTH_DEF = 8;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       wmask;
    logic [SQN_W-1:0] sqN;
    logic             except;
    logic             valid;
    logic             committed;
  } sq_entry_t;

  // a is younger than b when the wrapped difference is strictly positive.
  function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return !diff[SQN_W-1] && (diff != '0);
  endfunction
endpackage

// File: rtl/store_queue_fwd.sv
// Store-to-load forwarding lookup: per byte lane, the youngest matching store wins; the in-flight
// memory request is the oldest candidate.
module store_fwd_lookup
  import sq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  sq_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_idx,
  input  logic                       mem_valid,
  input  logic [31:2]                mem_addr,
  input  logic [31:0]                mem_data,
  input  logic [3:0]                 mem_mask,
  input  logic [31:0]                ld_addr,
  output logic [31:0]                fwd_data,
  output logic [3:0]                 fwd_mask
);
  localparam int IW = $clog2(DEPTH);

  sq_entry_t e;
  logic      unused_bits;

  // Scan oldest to youngest so later (younger) hits overwrite earlier ones.
  always_comb begin
    fwd_data    = '0;
    fwd_mask    = '0;
    e           = '0;
    unused_bits = ^ld_addr[1:0];
    for (int l = 0; l < 4; l++) begin
      if (mem_valid && mem_addr == ld_addr[31:2] && mem_mask[l]) begin
        fwd_mask[l]        = 1'b1;
        fwd_data[8*l +: 8] = mem_data[8*l +: 8];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      e           = entries[head_idx + IW'(k)];
      unused_bits = unused_bits ^ (^{e.addr[1:0], e.sqN, e.committed});
      if (e.valid && !e.except && e.addr[31:2] == ld_addr[31:2]) begin
        for (int l = 0; l < 4; l++) begin
          if (e.wmask[l]) begin
            fwd_mask[l]        = 1'b1;
            fwd_data[8*l +: 8] = e.data[8*l +: 8];
          end
        end
      end
    end
  end
endmodule

// File: rtl/store_queue.sv
// In-order store buffer between the store AGU and the data-memory write port.
// Define STORE_FWD_EN to enable combinational store-to-load forwarding on IN_ldAddr.
module store_queue
  import sq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  input  logic [31:0]      IN_addr,
  input  logic [31:0]      IN_data,
  input  logic [3:0]       IN_wmask,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic             IN_except,
  output logic             OUT_full,
  input  logic             IN_branch_v,
  input  logic [SQN_W-1:0] IN_branch_sqN,
  input  logic [SQN_W-1:0] IN_comLimit,
  input  logic             IN_memStall,
  output logic             OUT_memValid,
  output logic [31:0]      OUT_memAddr,
  output logic [31:0]      OUT_memData,
  output logic [3:0]       OUT_memMask,
  output logic             OUT_empty,
  input  logic [31:0]      IN_ldAddr,
  output logic [31:0]      OUT_fwdData,
  output logic [3:0]       OUT_fwdMask
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Handshakes: an AGU store transfers on IN_valid && !OUT_full; a write request transfers on
  // OUT_memValid && !IN_memStall and is held unchanged while stalled.
  sq_entry_t     q [DEPTH];
  logic [PW-1:0] head, tail, tail_flush, keep, count;
  logic [IW-1:0] head_idx, tail_idx;
  sq_entry_t     head_e;
  logic          head_ready, head_write, can_drain, do_drain, do_enq, flush_commit_err;
  logic          mem_valid;
  logic [31:2]   mem_addr;
  logic [31:0]   mem_data;
  logic [3:0]    mem_mask;
  logic          unused_lo;

  assign head_idx   = head[IW-1:0];
  assign tail_idx   = tail_flush[IW-1:0];
  assign count      = tail - head;
  assign OUT_full   = (head_idx == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign head_e     = q[head_idx];
  assign unused_lo  = ^head_e.addr[1:0];
  assign head_ready = head_e.valid && (head_e.committed || !sqn_younger(head_e.sqN, IN_comLimit));
  assign head_write = (head_e.wmask != 4'b0) && !head_e.except;
  assign can_drain  = !mem_valid || !IN_memStall;
  assign do_drain   = can_drain && head_ready;
  assign do_enq     = IN_valid && !OUT_full && !(IN_branch_v && sqn_younger(IN_sqN, IN_branch_sqN));

  // Entries are in program order, so the survivors of a flush are a prefix starting at head.
  always_comb begin
    keep             = '0;
    flush_commit_err = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PW'(k) < count) begin
        if (sqn_younger(q[head_idx + IW'(k)].sqN, IN_branch_sqN))
          flush_commit_err = flush_commit_err | q[head_idx + IW'(k)].committed;
        else
          keep = keep + PW'(1);
      end
    end
    tail_flush = IN_branch_v ? head + keep : tail;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        q[k].valid     <= 1'b0;
        q[k].committed <= 1'b0;
      end
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_mask  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (q[k].valid && !sqn_younger(q[k].sqN, IN_comLimit))
          q[k].committed <= 1'b1;
        if (IN_branch_v && q[k].valid && sqn_younger(q[k].sqN, IN_branch_sqN))
          q[k].valid <= 1'b0;
      end
      if (do_drain) begin
        q[head_idx].valid <= 1'b0;
        head              <= head + PW'(1);
      end
      // Fence/cache ops and excepted stores retire without a memory write.
      if (can_drain) begin
        mem_valid <= do_drain && head_write;
        if (do_drain && head_write) begin
          mem_addr <= head_e.addr[31:2];
          mem_data <= head_e.data;
          mem_mask <= head_e.wmask;
        end
      end
      if (do_enq)
        q[tail_idx] <= '{addr: IN_addr, data: IN_data, wmask: IN_wmask, sqN: IN_sqN,
                         except: IN_except, valid: 1'b1, committed: 1'b0};
      tail <= do_enq ? tail_flush + PW'(1) : tail_flush;
    end
  end

  assign OUT_memValid = mem_valid;
  assign OUT_memAddr  = {mem_addr, 2'b00};
  assign OUT_memData  = mem_data;
  assign OUT_memMask  = mem_mask;
  assign OUT_empty    = (head == tail) && !mem_valid;

`ifdef STORE_FWD_EN
  store_fwd_lookup #(.DEPTH(DEPTH)) u_fwd (
    .entries  (q),
    .head_idx (head_idx),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_mask (mem_mask),
    .ld_addr  (IN_ldAddr),
    .fwd_data (OUT_fwdData),
    .fwd_mask (OUT_fwdMask)
  );
`else
  logic unused_ld;
  assign unused_ld   = ^IN_ldAddr;
  assign OUT_fwdData = '0;
  assign OUT_fwdMask = '0;
`endif

  assert property (@(posedge clk) disable iff (!rst) !(IN_valid && OUT_full));
  assert property (@(posedge clk) disable iff (!rst) !(IN_branch_v && flush_commit_err));
endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed vector table, hand-written corner sequences and a randomized run
// against a queue-based reference model with a write scoreboard.
module tb_store_queue;
  import sq_pkg::*;

  localparam int DEPTH = 8;
`ifdef STORE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_except = 1'b0, in_branch_v = 1'b0, in_mem_stall = 1'b0;
  logic [31:0] in_addr = '0, in_data = '0, in_ld_addr = '0;
  logic [3:0]  in_wmask = '0;
  logic [6:0]  in_sqn = '0, in_branch_sqn = '0, in_com_limit = '0;
  logic        out_full, out_mem_valid, out_empty;
  logic [31:0] out_mem_addr, out_mem_data, out_fwd_data;
  logic [3:0]  out_mem_mask, out_fwd_mask;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .IN_valid(in_valid), .IN_addr(in_addr), .IN_data(in_data), .IN_wmask(in_wmask),
    .IN_sqN(in_sqn), .IN_except(in_except), .OUT_full(out_full),
    .IN_branch_v(in_branch_v), .IN_branch_sqN(in_branch_sqn), .IN_comLimit(in_com_limit),
    .IN_memStall(in_mem_stall), .OUT_memValid(out_mem_valid), .OUT_memAddr(out_mem_addr),
    .OUT_memData(out_mem_data), .OUT_memMask(out_mem_mask), .OUT_empty(out_empty),
    .IN_ldAddr(in_ld_addr), .OUT_fwdData(out_fwd_data), .OUT_fwdMask(out_fwd_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic [6:0] s, input logic e, input logic [6:0] c, input logic st,
                       input logic bv, input logic [6:0] bs);
    in_valid = v; in_addr = a; in_data = d; in_wmask = m; in_sqn = s; in_except = e;
    in_com_limit = c; in_mem_stall = st; in_branch_v = bv; in_branch_sqn = bs;
  endtask

  task automatic idle(input logic [6:0] c);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 1'b0, c, 1'b0, 1'b0, 7'h0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_write(input string name, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m);
    check({name, "_valid"}, out_mem_valid, 1'b1);
    check({name, "_word"}, {out_mem_addr, out_mem_data, out_mem_mask}, {a, d, m});
  endtask

  task automatic expect_idle(input string name, input logic empty_exp);
    check({name, "_valid"}, out_mem_valid, 1'b0);
    check({name, "_empty"}, out_empty, empty_exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(7'h0);
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] a, d;
    logic [3:0]  m;
    logic [6:0]  s, c;
    logic        st;
    logic        e_full, e_empty, e_mv;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_mask;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic [6:0] s,
                              logic [6:0] c, logic st, logic ef, logic ee, logic emv,
                              logic [31:0] ea, logic [31:0] ed, logic [3:0] em);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.m = m; r.s = s; r.c = c; r.st = st;
    r.e_full = ef; r.e_empty = ee; r.e_mv = emv; r.e_addr = ea; r.e_data = ed; r.e_mask = em;
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          sqn;
    logic [31:0] addr, data;
    logic [3:0]  mask;
    bit          except;
    bit          committed;
  } mentry_t;

  mentry_t     mq[$];
  logic [67:0] exp_q[$];
  bit          m_mv;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_mask;

  // Sequence numbers are unbounded ints here; live values stay within a small window.
  task automatic model_step(input bit v, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input int s, input bit e, input int c,
                            input bit st, input bit bv, input int bs);
    bit      was_full;
    mentry_t h;
    was_full = (mq.size() == DEPTH);
    foreach (mq[i]) if (mq[i].sqn <= c) mq[i].committed = 1'b1;
    if (!m_mv || !st) begin
      m_mv = 1'b0;
      if (mq.size() > 0 && mq[0].committed) begin
        h = mq.pop_front();
        if (h.mask != 4'h0 && !h.except) begin
          m_mv = 1'b1; m_addr = {h.addr[31:2], 2'b00}; m_data = h.data; m_mask = h.mask;
          exp_q.push_back({m_addr, m_data, m_mask});
        end
      end
    end
    if (bv) while (mq.size() > 0 && mq[$].sqn > bs) void'(mq.pop_back());
    if (v && !was_full && !(bv && s > bs))
      mq.push_back('{sqn: s, addr: a, data: d, mask: m, except: e, committed: 1'b0});
  endtask

  function automatic logic [35:0] model_fwd(input logic [31:0] la);
    logic [31:0] fd;
    logic [3:0]  fm;
    fd = '0; fm = '0;
    for (int l = 0; l < 4; l++) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!fm[l] && !mq[i].except && mq[i].addr[31:2] == la[31:2] && mq[i].mask[l]) begin
          fm[l] = 1'b1; fd[8*l +: 8] = mq[i].data[8*l +: 8];
        end
      end
      if (!fm[l] && m_mv && m_addr[31:2] == la[31:2] && m_mask[l]) begin
        fm[l] = 1'b1; fd[8*l +: 8] = m_data[8*l +: 8];
      end
    end
    return FWD_EN ? {fm, fd} : 36'h0;
  endfunction

  // ---------------- test sequence ----------------
  vec_t        vecs[9];
  logic [31:0] bases[4];
  logic [67:0] last_wr;

  initial begin
    int          nsq, cl, bsq;
    bit          v, bv, st, prev_mv, prev_stall, draining;
    logic [31:0] a;
    logic [35:0] fx;
    logic [3:0]  fe_mask;

    // Reset state
    do_reset();
    check("reset_empty", out_empty, 1'b1);
    check("reset_full", out_full, 1'b0);
    check("reset_mem_valid", out_mem_valid, 1'b0);
    check("reset_mem_word", {out_mem_addr, out_mem_data, out_mem_mask}, 68'h0);

    // Single store, commit, 3-cycle stall; then a store committed across sqN wrap
    vecs[0] = mk(1, 32'h100, 32'h0000BEEF, 4'h3, 7'd5, 7'd4, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 0, 0, 7'd5, 0, 0, 0, 1, 32'h100, 32'h0000BEEF, 4'h3);
    vecs[2] = mk(0, 0, 0, 0, 0, 7'd5, 1, 0, 0, 1, 32'h100, 32'h0000BEEF, 4'h3);
    vecs[3] = mk(0, 0, 0, 0, 0, 7'd5, 1, 0, 0, 1, 32'h100, 32'h0000BEEF, 4'h3);
    vecs[4] = mk(0, 0, 0, 0, 0, 7'd5, 1, 0, 0, 1, 32'h100, 32'h0000BEEF, 4'h3);
    vecs[5] = mk(0, 0, 0, 0, 0, 7'd5, 0, 0, 1, 0, 0, 0, 0);
    vecs[6] = mk(1, 32'h206, 32'h12345678, 4'hF, 7'h7E, 7'h7D, 0, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(0, 0, 0, 0, 0, 7'h02, 0, 0, 0, 1, 32'h204, 32'h12345678, 4'hF);
    vecs[8] = mk(0, 0, 0, 0, 0, 7'h02, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].s, 1'b0, vecs[i].c, vecs[i].st,
            1'b0, 7'h0);
      step();
      check($sformatf("vec%0d_full", i), out_full, vecs[i].e_full);
      check($sformatf("vec%0d_empty", i), out_empty, vecs[i].e_empty);
      check($sformatf("vec%0d_mem_valid", i), out_mem_valid, vecs[i].e_mv);
      if (vecs[i].e_mv)
        check($sformatf("vec%0d_mem_word", i), {out_mem_addr, out_mem_data, out_mem_mask},
              {vecs[i].e_addr, vecs[i].e_data, vecs[i].e_mask});
    end

    // Fill to full, then drain in order
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'(i), 4'hF, 7'(i), 1'b0, 7'd0, 1'b0, 1'b0, 7'h0);
      step();
      check($sformatf("fill%0d_full", i), out_full, i == 8);
    end
    check("fill_empty", out_empty, 1'b0);
    idle(7'd8);
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_write($sformatf("drain%0d", i), 32'h300 + 32'(4 * i), 32'(i), 4'hF);
      check($sformatf("drain%0d_full", i), out_full, 1'b0);
    end
    step();
    expect_idle("drain_done", 1'b1);

    // Flush younger than 4, with a same-cycle equal-sqN enqueue
    for (int s = 3; s <= 6; s++) begin
      drive(1'b1, 32'h400 + 32'(4 * s), 32'(s), 4'hF, 7'(s), 1'b0, 7'd2, 1'b0, 1'b0, 7'h0);
      step();
    end
    drive(1'b1, 32'h500, 32'h55, 4'hF, 7'd4, 1'b0, 7'd2, 1'b0, 1'b1, 7'd4);
    step();
    expect_idle("flush", 1'b0);
    idle(7'd6);
    step();
    expect_write("flush_d3", 32'h40C, 32'h3, 4'hF);
    step();
    expect_write("flush_d4", 32'h410, 32'h4, 4'hF);
    step();
    expect_write("flush_d4b", 32'h500, 32'h55, 4'hF);
    step();
    expect_idle("flush_done", 1'b1);

    // Excepted store retires silently; the next one drains right after
    drive(1'b1, 32'h600, 32'h22, 4'hF, 7'd2, 1'b1, 7'd1, 1'b0, 1'b0, 7'h0);
    step();
    drive(1'b1, 32'h604, 32'h33, 4'hF, 7'd3, 1'b0, 7'd1, 1'b0, 1'b0, 7'h0);
    step();
    idle(7'd3);
    step();
    expect_idle("except_retire", 1'b0);
    step();
    expect_write("except_next", 32'h604, 32'h33, 4'hF);
    step();
    expect_idle("except_done", 1'b1);

    // Forwarding: youngest store wins per lane
    drive(1'b1, 32'h200, 32'h11, 4'h1, 7'd1, 1'b0, 7'd0, 1'b0, 1'b0, 7'h0);
    step();
    drive(1'b1, 32'h200, 32'h2222, 4'h3, 7'd2, 1'b0, 7'd0, 1'b0, 1'b0, 7'h0);
    step();
    idle(7'd0);
    fe_mask = FWD_EN ? 4'h3 : 4'h0;
    in_ld_addr = 32'h200; #1;
    check("fwd_hit", {out_fwd_mask, out_fwd_data}, {fe_mask, FWD_EN ? 32'h2222 : 32'h0});
    in_ld_addr = 32'h203; #1;
    check("fwd_hit_offset", {out_fwd_mask, out_fwd_data}, {fe_mask, FWD_EN ? 32'h2222 : 32'h0});
    in_ld_addr = 32'h204; #1;
    check("fwd_miss", {out_fwd_mask, out_fwd_data}, 36'h0);
    in_ld_addr = 32'h200;
    idle(7'd2);
    step();
    expect_write("fwd_d1", 32'h200, 32'h11, 4'h1);
    check("fwd_inflight", {out_fwd_mask, out_fwd_data}, {fe_mask, FWD_EN ? 32'h2222 : 32'h0});
    step();
    expect_write("fwd_d2", 32'h200, 32'h2222, 4'h3);
    step();
    expect_idle("fwd_done", 1'b1);

    // Randomized run against the reference model
    do_reset();
    mq.delete(); exp_q.delete();
    m_mv = 1'b0; m_addr = '0; m_data = '0; m_mask = '0; last_wr = '0;
    bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h200; bases[3] = 32'h204;
    nsq = 1; cl = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      draining = (cyc >= 1470);
      in_ld_addr = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      #1;
      fx = model_fwd(in_ld_addr);
      check("rand_fwd", {out_fwd_mask, out_fwd_data}, fx);

      st = !draining && ($urandom_range(0, 9) < 3);
      if (draining) cl = nsq - 1;
      else if ($urandom_range(0, 2) == 0 && cl < nsq - 1) cl = $urandom_range(nsq - 1, cl + 1);
      bv = !draining && ($urandom_range(0, 19) == 0) && (nsq - 1 > cl);
      bsq = bv ? int'($urandom_range(nsq - 1, cl)) : 0;
      v = !draining && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      a = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      drive(v, a, $urandom, 4'($urandom_range(0, 15)), nsq[6:0], $urandom_range(0, 9) == 0,
            cl[6:0], st, bv, bsq[6:0]);
      model_step(v, in_addr, in_data, in_wmask, nsq, in_except, cl, st, bv, bsq);
      if (bv) nsq = bsq + 1;
      else if (v) nsq++;
      prev_mv = out_mem_valid;
      prev_stall = in_mem_stall;
      step();

      check("rand_full", out_full, mq.size() == DEPTH);
      check("rand_empty", out_empty, mq.size() == 0 && !m_mv);
      check("rand_mem_valid", out_mem_valid, m_mv);
      if (out_mem_valid) begin
        if (prev_mv && prev_stall) begin
          check("rand_mem_hold", {out_mem_addr, out_mem_data, out_mem_mask}, last_wr);
        end else if (exp_q.size() == 0) begin
          check("rand_unexpected_write", {out_mem_addr, out_mem_data, out_mem_mask}, 68'h0);
        end else begin
          last_wr = exp_q.pop_front();
          check("rand_write", {out_mem_addr, out_mem_data, out_mem_mask}, last_wr);
        end
      end
    end
    check("rand_writes_left", 68'(exp_q.size()), 68'h0);
    check("rand_final_empty", out_empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
